data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-port arbiter and access sequencer placed in front of the single-port 64-bit data memory. It shares the memory between the core load/store path (port 0) and a debug/loader port (port 1). It serialises their requests through a small state machine and drives the memory's read/write strobes. Requests that are misaligned or out of range are rejected without touching memory.

## Interface
Parameters:
- MEM_WORDS, 1024: number of 64-bit words in the memory; byte range is 0 .. MEM_WORDS*8-1.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req0 / req1  in  1  access request from port 0 / port 1, held until ack
- we0 / we1  in  1  1 = write (sd), 0 = read (ld)
- addr0 / addr1  in  64  byte address
- wdata0 / wdata1  in  64  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- err0 / err1  out  1  valid with ack: access rejected
- rdata  out  64  read result, valid while ackN is high; shared by both ports
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe (memory commits on clk edge)
- mem_address  out  64  byte address to memory
- mem_write_data  out  64  data to memory
- mem_read_data  in  64  combinational read data from memory

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any reqN is high, select a winner, latch its we/addr/wdata and port index, and go to ACCESS. Otherwise stay in IDLE.
- Arbitration is round-robin:
  - If only one port requests, that port wins.
  - If both request, the port not granted last wins.
  - The last-grant pointer resets to 1, so port 0 wins the first tie.
- Check in IDLE: the request is bad if addr[2:0] != 0 or addr >= MEM_WORDS*8.
- ACCESS:
  - Good request: drive mem_address = latched addr. Assert mem_read (read) or mem_write with mem_write_data (write) for exactly this cycle. For a read, capture mem_read_data into rdata at the end of the cycle.
  - Bad request: no strobe; the error flag is latched.
  - Next state is always RESP.
- RESP:
  - Pulse ackN for the granted port. errN = 1 if rejected.
  - rdata holds the read word. For writes and errors, rdata = 0.
  - Update the last-grant pointer, then go to IDLE.
- The loser's request stays pending; its inputs must stay stable until its ack.
- Requester protocol: drop req (or present a new request) in the cycle after ack. A req still high in IDLE is treated as a new request.
- Memory strobes are never high outside ACCESS. At most one strobe is high at a time.

## Timing
- Reset values: ack0/1 = 0, err0/1 = 0, rdata = 0, mem_read = 0, mem_write = 0, mem_address = 0, mem_write_data = 0, state = IDLE, pointer = 1.
- A request sampled in IDLE at edge N gives strobes in cycle N+1 and ack in cycle N+2.
- Throughput is one access per 3 cycles. Under continuous contention, accesses alternate ports.
- A write commits at the clk edge that ends ACCESS.
- Simultaneous req0 and req1 in IDLE are resolved by the pointer (or by the fixed-priority rule, see Configuration).
- Reset asserted mid-operation:
  - All outputs clear immediately (asynchronously).
  - A write in ACCESS is not committed, because mem_write drops before the edge.
  - No ack is issued for the aborted access.

## Configuration
- DATA_MEM_ARB_FIXED_PRIO_EN
  - Defined: port 0 always wins a tie, and the pointer is unused. Port 1 is served only when req0 is low in IDLE.
  - Undefined (default): round-robin as described above.

## Structure
- Package data_mem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - port index constants PORT_CORE = 0 and PORT_DBG = 1;
  - the WORD_BYTES = 8 constant.
- Sub-module data_mem_arb_pick: combinational winner select from req0, req1 and the pointer. The macro is applied inside this sub-module.
- FSM, request latch and response registers live in the top module.

## Test plan
- Single read, port 0: memory word 1 = 20, addr0 = 0x8.
  - mem_read is high for exactly 1 cycle with mem_address = 0x8.
  - ack0 arrives 2 cycles after the request, with rdata = 20 and err0 = 0.
- Single write, port 1: addr1 = 0x10, wdata1 = 0x55.
  - mem_write pulses for 1 cycle.
  - A later read of 0x10 returns 0x55.
  - ack1 is seen and ack0 never pulses.
- Simultaneous requests, both held high for 4 accesses:
  - Default build: grants go 0, 1, 0, 1.
  - With DATA_MEM_ARB_FIXED_PRIO_EN: port 0 is served repeatedly while req0 stays high, and port 1 is served only when req0 drops.
- Misaligned and out-of-range requests: addr0 = 0x4, then addr0 = MEM_WORDS*8.
  - ack0 is returned with err0 = 1 and rdata = 0.
  - mem_read and mem_write stay 0 throughout.
- Reset mid-access: assert rst_n = 0 during the ACCESS cycle of a write of 0xAA to 0x18.
  - All outputs go to 0 immediately.
  - The word at 0x18 is unchanged and no ack is issued.
  - After release, a new request completes normally.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic        PORT_CORE  = 1'b0;
  localparam logic        PORT_DBG   = 1'b1;
  localparam int unsigned WORD_BYTES = 8;

endpackage

// File: rtl/data_mem_arb_pick.sv
// Combinational winner select between the core and debug ports.
// DATA_MEM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 always wins a tie).
module data_mem_arb_pick
  import data_mem_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic vld_o,
  output logic port_o
);

  assign vld_o = req0_i | req1_i;

`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last_i;

  always_comb begin
    port_o = req0_i ? PORT_CORE : PORT_DBG;
  end
`else
  // On a tie the port that was not granted last goes next.
  always_comb begin
    port_o = PORT_CORE;
    if (req0_i && req1_i) begin
      port_o = (last_i == PORT_CORE) ? PORT_DBG : PORT_CORE;
    end else if (req1_i) begin
      port_o = PORT_DBG;
    end
  end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter and access sequencer in front of the single-port 64-bit
// data memory. Build option: DATA_MEM_ARB_FIXED_PRIO_EN (see data_mem_arb_pick).
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [63:0] addr0,
  input  logic [63:0] addr1,
  input  logic [63:0] wdata0,
  input  logic [63:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [63:0] rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_address,
  output logic [63:0] mem_write_data,
  input  logic [63:0] mem_read_data
);

  localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) * 64'(WORD_BYTES);

  state_e      state_q;
  logic        last_q;
  logic        port_q;
  logic        bad_q;
  logic        ack0_q, ack1_q;
  logic        err0_q, err1_q;
  logic [63:0] rdata_q;
  logic        mem_read_q, mem_write_q;
  logic [63:0] mem_address_q, mem_wdata_q;

  logic        grant_vld;
  logic        port_d;
  logic        we_d;
  logic        bad_d;
  logic [63:0] addr_d;
  logic [63:0] wdata_d;

  data_mem_arb_pick u_pick (
    .req0_i (req0),
    .req1_i (req1),
    .last_i (last_q),
    .vld_o  (grant_vld),
    .port_o (port_d)
  );

  always_comb begin
    we_d    = (port_d == PORT_DBG) ? we1    : we0;
    addr_d  = (port_d == PORT_DBG) ? addr1  : addr0;
    wdata_d = (port_d == PORT_DBG) ? wdata1 : wdata0;
    bad_d   = (addr_d[2:0] != 3'd0) || (addr_d >= MEM_BYTES);
  end

  // Strobes are registered on entry to ACCESS and cleared on exit, so they
  // are high for exactly the ACCESS cycle and drop at once on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_q        <= PORT_DBG;
      port_q        <= PORT_CORE;
      bad_q         <= 1'b0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      err0_q        <= 1'b0;
      err1_q        <= 1'b0;
      rdata_q       <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            port_q        <= port_d;
            bad_q         <= bad_d;
            mem_address_q <= addr_d;
            mem_wdata_q   <= (we_d && !bad_d) ? wdata_d : '0;
            mem_read_q    <= !bad_d && !we_d;
            mem_write_q   <= !bad_d && we_d;
            state_q       <= ACCESS;
          end
        end
        ACCESS: begin
          mem_read_q    <= 1'b0;
          mem_write_q   <= 1'b0;
          mem_address_q <= '0;
          mem_wdata_q   <= '0;
          rdata_q       <= mem_read_q ? mem_read_data : '0;
          ack0_q        <= (port_q == PORT_CORE);
          ack1_q        <= (port_q == PORT_DBG);
          err0_q        <= (port_q == PORT_CORE) && bad_q;
          err1_q        <= (port_q == PORT_DBG) && bad_q;
          state_q       <= RESP;
        end
        RESP: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          err0_q  <= 1'b0;
          err1_q  <= 1'b0;
          rdata_q <= '0;
          last_q  <= port_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack0           = ack0_q;
  assign ack1           = ack1_q;
  assign err0           = err0_q;
  assign err1           = err1_q;
  assign rdata          = rdata_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter with a behavioural memory and a
// response scoreboard; honours DATA_MEM_ARB_FIXED_PRIO_EN when defined.
module tb_data_mem_arbiter;

  localparam int MEM_WORDS = 1024;

  typedef struct packed {
    logic        port;
    logic        err;
    logic [63:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [63:0] addr0 = '0, addr1 = '0;
  logic [63:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, err0, err1;
  logic [63:0] rdata;
  logic        mem_read, mem_write;
  logic [63:0] mem_address, mem_write_data, mem_read_data;

  logic [63:0] mem [0:MEM_WORDS-1];
  logic        pl_we = 1'b0;
  logic [9:0]  pl_idx = '0;
  logic [63:0] pl_data = '0;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req0           (req0),
    .req1           (req1),
    .we0            (we0),
    .we1            (we1),
    .addr0          (addr0),
    .addr1          (addr1),
    .wdata0         (wdata0),
    .wdata1         (wdata1),
    .ack0           (ack0),
    .ack1           (ack1),
    .err0           (err0),
    .err1           (err1),
    .rdata          (rdata),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  assign mem_read_data = mem[mem_address[12:3]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_address[12:3]] <= mem_write_data;
    else if (pl_we) mem[pl_idx] <= pl_data;
  end

  task automatic preload(input int idx, input logic [63:0] d);
    @(posedge clk); #1;
    pl_we = 1'b1; pl_idx = idx[9:0]; pl_data = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic push_exp(input logic p, input logic e, input logic [63:0] d);
    exp_t x;
    x.port = p; x.err = e; x.rdata = d;
    sb.push_back(x);
  endtask

  // Drives one request, waits for its ack and scores the response.
  task automatic issue(input logic p, input logic w, input logic [63:0] a,
                       input logic [63:0] wd, output int lat, output int rds,
                       output int wrs, output logic [63:0] rd_addr);
    exp_t e;
    @(posedge clk); #1;
    if (p == 1'b0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = wd; end
    else           begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = wd; end
    lat = -1; rds = 0; wrs = 0; rd_addr = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (mem_read)  begin rds++; rd_addr = mem_address; end
      if (mem_write) wrs++;
      if (ack0 || ack1) begin lat = c; break; end
    end
    tests++;
    if (lat < 0) begin
      fails++; $display("FAIL ack_timeout port=%0d got no ack, required ack", p);
    end else if (sb.size() == 0) begin
      fails++; $display("FAIL unexpected_ack got ack0=%b ack1=%b, required none", ack0, ack1);
    end else begin
      e = sb.pop_front();
      tests++;
      if ({ack1, ack0} !== (e.port ? 2'b10 : 2'b01)) begin
        fails++; $display("FAIL ack_port got %b, required %b", {ack1, ack0}, e.port ? 2'b10 : 2'b01);
      end
      tests++;
      if ((e.port ? err1 : err0) !== e.err) begin
        fails++; $display("FAIL err got %b, required %b", e.port ? err1 : err0, e.err);
      end
      tests++;
      if (rdata !== e.rdata) begin
        fails++; $display("FAIL rdata got %h, required %h", rdata, e.rdata);
      end
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({ack0, ack1, err0, err1, mem_read, mem_write} !== 6'b0) begin
      fails++; $display("FAIL reset_ctrl got %b, required 000000", {ack0, ack1, err0, err1, mem_read, mem_write});
    end
    tests++;
    if (rdata !== 64'd0) begin fails++; $display("FAIL reset_rdata got %h, required 0", rdata); end
    tests++;
    if (mem_address !== 64'd0) begin fails++; $display("FAIL reset_addr got %h, required 0", mem_address); end
    tests++;
    if (mem_write_data !== 64'd0) begin fails++; $display("FAIL reset_wdata got %h, required 0", mem_write_data); end
    rst_n = 1'b1;
    preload(1, 64'd20);
    preload(3, 64'h1234);
    preload(4, 64'h4444_0000);
    preload(5, 64'h5555_0001);
    preload(MEM_WORDS - 1, 64'hFEED_BEEF);
    tests++;
    if ({ack0, ack1, mem_read, mem_write} !== 4'b0) begin
      fails++; $display("FAIL idle_quiet got %b, required 0000", {ack0, ack1, mem_read, mem_write});
    end
  endtask

  task automatic test_contention();
    exp_t e;
    int   n = 0;
    int   n_exp;
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
    n_exp = 5;
    for (int i = 0; i < 4; i++) push_exp(1'b0, 1'b0, 64'h4444_0000);
    push_exp(1'b1, 1'b0, 64'h5555_0001);
`else
    n_exp = 4;
    for (int i = 0; i < 2; i++) begin
      push_exp(1'b0, 1'b0, 64'h4444_0000);
      push_exp(1'b1, 1'b0, 64'h5555_0001);
    end
`endif
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'h20;
    req1 = 1'b1; we1 = 1'b0; addr1 = 64'h28;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        n++;
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL contention_extra_ack got ack0=%b ack1=%b, required none", ack0, ack1);
        end else begin
          e = sb.pop_front();
          tests++;
          if ({ack1, ack0} !== (e.port ? 2'b10 : 2'b01)) begin
            fails++; $display("FAIL contention_grant%0d got %b, required %b", n, {ack1, ack0}, e.port ? 2'b10 : 2'b01);
          end
          tests++;
          if (rdata !== e.rdata) begin
            fails++; $display("FAIL contention_rdata%0d got %h, required %h", n, rdata, e.rdata);
          end
        end
        if (n == n_exp) break;
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
        if (n == 4) begin @(posedge clk); #1; req0 = 1'b0; end
`endif
      end
    end
    tests++;
    if (n != n_exp) begin fails++; $display("FAIL contention_count got %0d, required %0d", n, n_exp); end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    sb.delete();
  endtask

  task automatic test_single_read();
    int lat, rds, wrs;
    logic [63:0] ra;
    push_exp(1'b0, 1'b0, 64'd20);
    issue(1'b0, 1'b0, 64'h8, 64'd0, lat, rds, wrs, ra);
    tests++;
    if (lat != 2) begin fails++; $display("FAIL read_latency got %0d, required 2", lat); end
    tests++;
    if (rds != 1 || wrs != 0) begin fails++; $display("FAIL read_strobes got rd=%0d wr=%0d, required rd=1 wr=0", rds, wrs); end
    tests++;
    if (ra !== 64'h8) begin fails++; $display("FAIL read_addr got %h, required 8", ra); end
  endtask

  task automatic test_single_write();
    int lat, rds, wrs;
    logic [63:0] ra;
    push_exp(1'b1, 1'b0, 64'd0);
    issue(1'b1, 1'b1, 64'h10, 64'h55, lat, rds, wrs, ra);
    tests++;
    if (wrs != 1 || rds != 0) begin fails++; $display("FAIL write_strobes got rd=%0d wr=%0d, required rd=0 wr=1", rds, wrs); end
    tests++;
    if (mem[2] !== 64'h55) begin fails++; $display("FAIL write_commit got %h, required 55", mem[2]); end
    push_exp(1'b1, 1'b0, 64'h55);
    issue(1'b1, 1'b0, 64'h10, 64'd0, lat, rds, wrs, ra);
    tests++;
    if (lat != 2) begin fails++; $display("FAIL readback_latency got %0d, required 2", lat); end
  endtask

  task automatic test_errors();
    int lat, rds, wrs;
    logic [63:0] ra;
    push_exp(1'b0, 1'b1, 64'd0);
    issue(1'b0, 1'b0, 64'h4, 64'd0, lat, rds, wrs, ra);
    tests++;
    if (rds != 0 || wrs != 0) begin fails++; $display("FAIL misalign_strobes got rd=%0d wr=%0d, required 0", rds, wrs); end
    push_exp(1'b0, 1'b1, 64'd0);
    issue(1'b0, 1'b1, 64'(MEM_WORDS * 8), 64'hDEAD, lat, rds, wrs, ra);
    tests++;
    if (rds != 0 || wrs != 0) begin fails++; $display("FAIL range_strobes got rd=%0d wr=%0d, required 0", rds, wrs); end
    push_exp(1'b0, 1'b0, 64'hFEED_BEEF);
    issue(1'b0, 1'b0, 64'(MEM_WORDS * 8 - 8), 64'd0, lat, rds, wrs, ra);
    tests++;
    if (rds != 1) begin fails++; $display("FAIL last_word_strobe got rd=%0d, required 1", rds); end
  endtask

  task automatic test_reset_mid_access();
    int   lat, rds, wrs;
    logic [63:0] ra;
    logic stray = 1'b0;
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 64'h18; wdata0 = 64'hAA;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({mem_write, mem_address, mem_write_data} !== {1'b1, 64'h18, 64'hAA}) begin
      fails++; $display("FAIL mid_access_strobe got wr=%b addr=%h data=%h, required 1/18/aa", mem_write, mem_address, mem_write_data);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({ack0, ack1, err0, err1, mem_read, mem_write, rdata, mem_address, mem_write_data} !== '0) begin
      fails++; $display("FAIL async_clear got ack=%b%b wr=%b addr=%h data=%h, required all 0", ack0, ack1, mem_write, mem_address, mem_write_data);
    end
    @(posedge clk); #1;
    req0 = 1'b0; we0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (ack0 || ack1) stray = 1'b1;
    end
    tests++;
    if (stray !== 1'b0) begin fails++; $display("FAIL aborted_ack got 1, required 0"); end
    tests++;
    if (mem[3] !== 64'h1234) begin fails++; $display("FAIL aborted_commit got %h, required 1234", mem[3]); end
    push_exp(1'b0, 1'b0, 64'h1234);
    issue(1'b0, 1'b0, 64'h18, 64'd0, lat, rds, wrs, ra);
    tests++;
    if (lat != 2) begin fails++; $display("FAIL post_reset_latency got %0d, required 2", lat); end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_read();
    test_single_write();
    test_errors();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
